// File: rtl/comparator_selftest.sv
// On-chip self-test engine for magnitude comparators: sweeps every (a,b) pair,
// samples agtb after a settle time and checks it against a golden a > b.
module comparator_selftest #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 agtb_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [2*WIDTH-1:0]   IDX_LAST    = '1;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] idx;
    logic [7:0]         settle_cnt;
    logic               golden;
    logic               sample;

    // Operands come straight from the index so they hold the last vector in DONE.
    assign a_out  = idx[2*WIDTH-1:WIDTH];
    assign b_out  = idx[WIDTH-1:0];
    assign golden = (a_out > b_out);
    assign sample = (state == ST_APPLY) && (settle_cnt == SETTLE_LAST);

    assign busy = (state == ST_APPLY);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        idx        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end
                ST_APPLY: begin
                    if (sample) begin
                        if (agtb_in != golden) begin
                            err_count <= err_count + 1'b1;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_a     <= a_out;
                                fail_b     <= b_out;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            settle_cnt <= '0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_selftest.sv
// Directed bench for comparator_selftest with a behavioural comparator whose
// fault mode is selectable per run.
module tb_comparator_selftest;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    int         mode0 = 0;
    int         mode1 = 0;
    int         checks = 0;
    int         errors = 0;

    logic [1:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
    logic       agtb0, agtb1;
    logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
    logic [4:0] ec0, ec1;

    always #5 clk = ~clk;

    // mode: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 computes a<b
    function automatic logic cmp_model(input int mode, input logic [1:0] a, input logic [1:0] b);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return a < b;
            default: return a > b;
        endcase
    endfunction

    always_comb agtb0 = cmp_model(mode0, a0, b0);
    always_comb agtb1 = cmp_model(mode1, a1, b1);

    comparator_selftest #(.WIDTH(2), .SETTLE(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .a_out(a0), .b_out(b0), .agtb_in(agtb0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
        .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0)
    );

    comparator_selftest #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .a_out(a1), .b_out(b1), .agtb_in(agtb1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero0(input string tag);
        check({tag, " outs"}, {a0, b0, busy0, done0, pass0, fv0, fa0, fb0}, 0);
        check({tag, " err_count"}, ec0, 0);
    endtask

    // Pulse start for one edge; afterwards we sit just after E0.
    task automatic launch0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic fault_run(input int mode, input int exp_err, input int exp_fa, input int exp_fb, input string tag);
        mode0 = mode;
        launch0();
        check({tag, " busy"}, busy0, 1);
        repeat (64) tick();
        check({tag, " done"}, done0, 1);
        check({tag, " err_count"}, ec0, exp_err);
        check({tag, " pass"}, pass0, 0);
        check({tag, " fail_valid"}, fv0, 1);
        check({tag, " fail_a"}, fa0, exp_fa);
        check({tag, " fail_b"}, fb0, exp_fb);
    endtask

    initial begin
        #12;
        check_all_zero0("reset");
        check("reset dut1", {busy1, done1, pass1, ec1}, 0);
        reset_n = 1'b1;
        tick();

        // Correct comparator: sweep order, hold time and final status.
        mode0 = 0;
        launch0();
        check("run0 busy after E0", busy0, 1);
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("seq a k%0d c%0d", k, c), a0, k / 4);
                check($sformatf("seq b k%0d c%0d", k, c), b0, k % 4);
                if (k == 15 && c == 3) check("run0 done before last edge", done0, 0);
                tick();
            end
        end
        check("run0 done", done0, 1);
        check("run0 busy", busy0, 0);
        check("run0 pass", pass0, 1);
        check("run0 err_count", ec0, 0);
        check("run0 fail_valid", fv0, 0);
        check("run0 hold a", a0, 3);
        check("run0 hold b", b0, 3);

        // Faulty comparators, each restarted directly from DONE.
        fault_run(1, 6, 1, 0, "stuck0");
        fault_run(2, 10, 0, 0, "stuck1");
        fault_run(3, 12, 0, 1, "altb");

        // Restart from DONE clears status at once.
        mode0 = 0;
        launch0();
        check("restart done", done0, 0);
        check("restart err_count", ec0, 0);
        check("restart fail_valid", fv0, 0);
        check("restart pass", pass0, 0);

        // Advance to idx=7 (a=1,b=3) mid-settle, then reset asynchronously.
        repeat (7 * 4 + 1) tick();
        check("mid a", a0, 1);
        check("mid b", b0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero0("async reset");
        #1;
        reset_n = 1'b1;
        tick();
        check("post reset idle", {busy0, done0}, 0);
        launch0();
        repeat (63) tick();
        check("rerun done at 63", done0, 0);
        tick();
        check("rerun done at 64", done0, 1);
        check("rerun pass", pass0, 1);

        // SETTLE=1 with start held high, stuck-at-1 so the clear is visible.
        mode1 = 2;
        start1 = 1'b1;
        tick();
        check("s1 busy at E0", busy1, 1);
        repeat (15) tick();
        check("s1 busy at 15", busy1, 1);
        check("s1 a at 15", a1, 3);
        check("s1 b at 15", b1, 3);
        tick();
        check("s1 done at 16", done1, 1);
        check("s1 err_count", ec1, 10);
        check("s1 fail a", fa1, 0);
        tick();
        check("s1 restart done", done1, 0);
        check("s1 restart busy", busy1, 1);
        check("s1 restart err_count", ec1, 0);
        check("s1 restart a", a1, 0);
        start1 = 1'b0;
        repeat (16) tick();
        check("s1 second done", done1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
